// File: rtl/sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer_if
// Description : Bundles the serial input, framing strobe and the parallel
//               valid/ready output of the SIPO deserializer.
//
//               slave  : the deserializer side (consumes serial bits,
//                        drives the parallel word and status pulses)
//               master : the link/consumer side (drives serial bits and
//                        pout_ready, observes the parallel word)
//
//               Signals
//                 sin        serial data bit
//                 sin_valid  qualifies sin for the current cycle
//                 sof        start of frame, meaningful only with sin_valid
//                 pout       received parallel word (holding register)
//                 pout_valid pout holds an unconsumed word
//                 pout_ready consumer accepts pout this cycle
//                 frame_err  one-cycle pulse, partial frame discarded
//                 overrun    one-cycle pulse, completed word dropped
//                 parity_err parity result for the word in pout
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_valid;
    logic             sof;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin,
        output sin_valid,
        output sof,
        output pout_ready,
        input  pout,
        input  pout_valid,
        input  frame_err,
        input  overrun,
        input  parity_err
    );

    modport slave (
        input  sin,
        input  sin_valid,
        input  sof,
        input  pout_ready,
        output pout,
        output pout_valid,
        output frame_err,
        output overrun,
        output parity_err
    );
endinterface
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Serial-in, parallel-out receiver. Collects a frame of serial
//               bits, started by a start-of-frame strobe, into a parallel
//               word that is offered on a valid/ready holding register.
//               Reports resynchronisation (sof mid-frame) and overrun
//               (completed word with the holding register still full).
//
// Parameters  : WIDTH     data bits per frame, 2..32
//               MSB_FIRST 1: first received bit ends in pout[WIDTH-1]
//                         0: first received bit ends in pout[0]
//
// Ports       : clk  system clock, rising edge
//               rst  asynchronous, active-high reset
//               bus  sipo_deserializer_if.slave
//                    in : sin, sin_valid, sof, pout_ready
//                    out: pout, pout_valid, frame_err, overrun, parity_err
//
// Option      : SIPO_PARITY_EN - when defined, each frame carries one
//               trailing even-parity bit after the data bits. The parity bit
//               is checked but not stored; parity_err is registered with pout.
//               When undefined, parity_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sipo_deserializer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
`ifdef SIPO_PARITY_EN
    localparam int c_frame_bits = WIDTH + 1;
`else
    localparam int c_frame_bits = WIDTH;
`endif
    // Counter holds values 0..WIDTH+1 so it never wraps in either build.
    localparam int c_cnt_w = $clog2(WIDTH + 2);
    localparam logic [c_cnt_w-1:0] c_frame_len = c_cnt_w'(c_frame_bits);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               state_q,      state_d;
    logic [c_cnt_w-1:0]   count_q,      count_d;
    logic [WIDTH-1:0]     shift_q,      shift_d;
    logic [WIDTH-1:0]     pout_q,       pout_d;
    logic                 pout_valid_q, pout_valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 overrun_q,    overrun_d;
`ifdef SIPO_PARITY_EN
    logic                 parity_acc_q, parity_acc_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic [c_cnt_w-1:0]   w_count_inc;
    logic                 w_done;
    logic [WIDTH-1:0]     w_word;

    // Insert one new bit so that after WIDTH insertions the first bit sits
    // at the end selected by MSB_FIRST.
    function automatic logic [WIDTH-1:0] f_shift(
        input logic [WIDTH-1:0] cur,
        input logic             b
    );
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[WIDTH-2:0], b};
        end else begin
            res = {b, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    assign w_count_inc = count_q + c_cnt_one;

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        pout_d       = pout_q;
        pout_valid_d = pout_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;
        w_done       = 1'b0;
`ifdef SIPO_PARITY_EN
        parity_acc_d = parity_acc_q;
        parity_err_d = parity_err_q;
        // The final sampled bit is the parity bit, so the data word is
        // already complete in the shift register.
        w_word       = shift_q;
`else
        w_word       = f_shift(shift_q, bus.sin);
`endif

        // Consumer takes the current word; a load below may re-set valid.
        if (bus.pout_ready) begin
            pout_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Bits without sof are not part of any frame and dropped.
                if (bus.sin_valid && bus.sof) begin
                    shift_d      = f_shift('0, bus.sin);
                    count_d      = c_cnt_one;
                    state_d      = ST_SHIFT;
`ifdef SIPO_PARITY_EN
                    parity_acc_d = bus.sin;
`endif
                end
            end
            ST_SHIFT: begin
                if (bus.sin_valid) begin
                    if (bus.sof) begin
                        // Resync: drop the partial word and restart with
                        // this bit as bit 0. Holding register untouched.
                        frame_err_d  = 1'b1;
                        shift_d      = f_shift('0, bus.sin);
                        count_d      = c_cnt_one;
`ifdef SIPO_PARITY_EN
                        parity_acc_d = bus.sin;
`endif
                    end else if (w_count_inc == c_frame_len) begin
                        // Last bit of the frame: finish on this same edge so
                        // a sof on the next cycle starts a new frame.
                        w_done  = 1'b1;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        shift_d      = f_shift(shift_q, bus.sin);
                        count_d      = w_count_inc;
`ifdef SIPO_PARITY_EN
                        parity_acc_d = parity_acc_q ^ bus.sin;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completed word: load if the holding register is empty or being
        // drained this cycle, otherwise drop it and flag the loss.
        if (w_done) begin
            if (!pout_valid_q || bus.pout_ready) begin
                pout_d       = w_word;
                pout_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                // Even parity: XOR over data and parity bit must be 0.
                parity_err_d = parity_acc_q ^ bus.sin;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            pout_q       <= pout_d;
            pout_valid_q <= pout_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_acc_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_acc_q <= parity_acc_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.pout       = pout_q;
    assign bus.pout_valid = pout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire
